// File: rtl/alu_mb_sequencer.sv
// alu_mb_sequencer
// ----------------
// Multi-byte ADD/SUB sequencer acting as the initiator for an external 8-bit
// combinational ALU. A WIDTH-bit command is accepted over a valid/ready
// handshake and worked through one byte per cycle, LSB first. The ALU has no
// carry-in, so a carry/borrow from the previous byte is folded in with an extra
// INC/DEC pass (the FIX state) on the raw byte result.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake; cmd_op 1=ADD, 2=SUB, else illegal
//   cmd_a, cmd_b            operands (latched at accept)
//   rsp_valid/rsp_ready     response handshake
//   rsp_data                WIDTH-bit result (modulo 2^WIDTH)
//   rsp_carry               carry-out (ADD) or borrow-out (SUB) of the top byte
//   rsp_zero                rsp_data == 0
//   rsp_err                 command carried an illegal opcode
//   alu_in_a/b, alu_opcode  registered drive into the ALU
//   alu_out, alu_carry      ALU results, sampled on the same rising edge
//   alu_zero                not needed; kept so the ALU interface is complete
module alu_mb_sequencer #(
  parameter int NBYTES = 4,
  localparam int WIDTH = 8 * NBYTES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [7:0]       alu_in_a,
  output logic [7:0]       alu_in_b,
  output logic [3:0]       alu_opcode,
  input  logic [7:0]       alu_out,
  input  logic             alu_zero,
  input  logic             alu_carry
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_INC = 4'h3;
  localparam logic [3:0] OP_DEC = 4'h4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP   = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_prev_q, carry_prev_d;
  logic             c1_q, c1_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;
  logic [7:0]       alu_in_a_q, alu_in_a_d;
  logic [7:0]       alu_in_b_q, alu_in_b_d;
  logic [3:0]       alu_opcode_q, alu_opcode_d;

  // Per-cycle byte completion, shared by the OP (no carry) and FIX paths.
  logic             byte_done;
  logic [7:0]       byte_val;
  logic             carry_next;
  logic [IW-1:0]    idx_nx;
  logic             last_byte;

  // alu_zero carries no information the sequencer needs.
  logic             unused_alu_zero;
  assign unused_alu_zero = alu_zero;

  assign idx_nx    = idx_q + IW'(1);
  assign last_byte = (idx_q == IW'(NBYTES - 1));

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    idx_d        = idx_q;
    carry_prev_d = carry_prev_q;
    c1_d         = c1_q;
    result_d     = result_q;
    cmd_ready_d  = cmd_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    alu_in_a_d   = alu_in_a_q;
    alu_in_b_d   = alu_in_b_q;
    alu_opcode_d = alu_opcode_q;
    byte_done    = 1'b0;
    byte_val     = 8'h00;
    carry_next   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          a_d          = cmd_a;
          b_d          = cmd_b;
          op_d         = cmd_op;
          idx_d        = '0;
          carry_prev_d = 1'b0;
          c1_d         = 1'b0;
          result_d     = '0;
          cmd_ready_d  = 1'b0;
          if (cmd_op == OP_ADD || cmd_op == OP_SUB) begin
            state_d      = S_OP;
            alu_in_a_d   = cmd_a[7:0];
            alu_in_b_d   = cmd_b[7:0];
            alu_opcode_d = cmd_op;
          end else begin
            // Response fields are loaded now; rsp_valid is raised by DONE on
            // the following edge, so an error reports one cycle after accept.
            state_d    = S_DONE;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            rsp_carry_d = 1'b0;
            rsp_zero_d = 1'b1;
          end
        end
      end

      S_OP: begin
        if (!carry_prev_q) begin
          byte_done  = 1'b1;
          byte_val   = alu_out;
          carry_next = alu_carry;
        end else begin
          // Raw byte result goes back through the ALU to absorb the carry.
          c1_d         = alu_carry;
          state_d      = S_FIX;
          alu_in_a_d   = alu_out;
          alu_in_b_d   = 8'h00;
          alu_opcode_d = (op_q == OP_ADD) ? OP_INC : OP_DEC;
        end
      end

      S_FIX: begin
        // At most one of c1/alu_carry can be set; either one propagates.
        byte_done  = 1'b1;
        byte_val   = alu_out;
        carry_next = c1_q | alu_carry;
      end

      S_DONE: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (byte_done) begin
      result_d[idx_q*8 +: 8] = byte_val;
      carry_prev_d           = carry_next;
      if (last_byte) begin
        state_d      = S_DONE;
        rsp_valid_d  = 1'b1;
        rsp_data_d   = result_d;
        rsp_carry_d  = carry_next;
        rsp_zero_d   = (result_d == '0);
        rsp_err_d    = 1'b0;
        alu_in_a_d   = 8'h00;
        alu_in_b_d   = 8'h00;
        alu_opcode_d = OP_NOP;
      end else begin
        state_d      = S_OP;
        idx_d        = idx_nx;
        alu_in_a_d   = a_q[idx_nx*8 +: 8];
        alu_in_b_d   = b_q[idx_nx*8 +: 8];
        alu_opcode_d = op_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 4'h0;
      idx_q        <= '0;
      carry_prev_q <= 1'b0;
      c1_q         <= 1'b0;
      result_q     <= '0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      alu_in_a_q   <= 8'h00;
      alu_in_b_q   <= 8'h00;
      alu_opcode_q <= OP_NOP;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      idx_q        <= idx_d;
      carry_prev_q <= carry_prev_d;
      c1_q         <= c1_d;
      result_q     <= result_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
      alu_in_a_q   <= alu_in_a_d;
      alu_in_b_q   <= alu_in_b_d;
      alu_opcode_q <= alu_opcode_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;
  assign alu_in_a   = alu_in_a_q;
  assign alu_in_b   = alu_in_b_q;
  assign alu_opcode = alu_opcode_q;

endmodule

// File: tb/tb_alu_mb_sequencer.sv
// Testbench for alu_mb_sequencer (NBYTES = 4) with a behavioural 8-bit ALU.
module tb_alu_mb_sequencer;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_op;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_carry;
  logic         rsp_zero;
  logic         rsp_err;
  logic [7:0]   alu_in_a;
  logic [7:0]   alu_in_b;
  logic [3:0]   alu_opcode;
  logic [7:0]   alu_out;
  logic         alu_zero;
  logic         alu_carry;

  always #5 clk = ~clk;

  alu_mb_sequencer #(.NBYTES(NB)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry)
  );

  // Behavioural 8-bit ALU: ADD/SUB/INC/DEC, carry = carry-out or borrow.
  always_comb begin
    alu_out   = 8'h00;
    alu_carry = 1'b0;
    case (alu_opcode)
      4'h1: begin
        alu_out   = alu_in_a + alu_in_b;
        alu_carry = (int'(alu_in_a) + int'(alu_in_b)) > 255;
      end
      4'h2: begin
        alu_out   = alu_in_a - alu_in_b;
        alu_carry = alu_in_a < alu_in_b;
      end
      4'h3: begin
        alu_out   = alu_in_a + 8'h01;
        alu_carry = (alu_in_a == 8'hFF);
      end
      4'h4: begin
        alu_out   = alu_in_a - 8'h01;
        alu_carry = (alu_in_a == 8'h00);
      end
      default: begin
        alu_out   = 8'h00;
        alu_carry = 1'b0;
      end
    endcase
  end
  assign alu_zero = (alu_out == 8'h00);

  int n_cmp = 0;
  int n_mis = 0;
  int last_wait;
  logic [W-1:0] exp_d;
  logic         exp_c, exp_z, exp_e;
  int           exp_lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic; latency = NBYTES plus one per byte
  // 1..NBYTES-1 whose incoming carry (from the lower bytes) is set.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned la, lb, m;
    bit cin;
    la = 64'(a);
    lb = 64'(b);
    if (op != 4'h1 && op != 4'h2) begin
      exp_d = '0; exp_c = 1'b0; exp_z = 1'b1; exp_e = 1'b1; exp_lat = 1;
    end else begin
      exp_e = 1'b0;
      if (op == 4'h1) begin
        exp_d = W'(la + lb);
        exp_c = ((la + lb) >> W) != 0;
      end else begin
        exp_d = W'(la - lb);
        exp_c = la < lb;
      end
      exp_z   = (exp_d == '0);
      exp_lat = NB;
      for (int i = 1; i < NB; i++) begin
        m = (64'd1 << (8 * i)) - 64'd1;
        if (op == 4'h1) cin = (((la & m) + (lb & m)) >> (8 * i)) != 0;
        else            cin = (la & m) < (lb & m);
        if (cin) exp_lat++;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int w = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    while (!cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk("accept_timeout", 64'(w), 64'(0));
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_a = $urandom; cmd_b = $urandom; cmd_op = 4'($urandom);
    last_wait = w;
  endtask

  task automatic wait_rsp(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
    int lat = 0;
    model(op, a, b);
    while (!rsp_valid && lat < 40) begin
      if (exp_e) chk({tag, "_aluop"}, 64'(alu_opcode), 64'(0));
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_lat"},   64'(lat),       64'(exp_lat));
    chk({tag, "_data"},  64'(rsp_data),  64'(exp_d));
    chk({tag, "_carry"}, 64'(rsp_carry), 64'(exp_c));
    chk({tag, "_zero"},  64'(rsp_zero),  64'(exp_z));
    chk({tag, "_err"},   64'(rsp_err),   64'(exp_e));
    chk({tag, "_rdy"},   64'(cmd_ready), 64'(0));
    chk({tag, "_aluop_done"}, 64'(alu_opcode), 64'(0));
  endtask

  task automatic drain(input int hold, input string tag);
    rsp_ready = 1'b0;
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_hold_valid"}, 64'(rsp_valid), 64'(1));
      chk({tag, "_hold_data"},  64'({rsp_carry, rsp_zero, rsp_err, rsp_data}),
          64'({exp_c, exp_z, exp_e, exp_d}));
      chk({tag, "_hold_rdy"},   64'(cmd_ready), 64'(0));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_post_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_post_rdy"},   64'(cmd_ready), 64'(1));
  endtask

  task automatic run(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input int hold, input string tag);
    issue(op, a, b);
    wait_rsp(op, a, b, tag);
    drain(hold, tag);
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    for (int i = 0; i < NB; i++) begin
      case ($urandom_range(0, 3))
        0:       v[i*8 +: 8] = 8'h00;
        1:       v[i*8 +: 8] = 8'hFF;
        default: v[i*8 +: 8] = 8'($urandom);
      endcase
    end
    return v;
  endfunction

  initial begin
    logic [3:0] rop;
    logic [W-1:0] ra, rb;
    bit seen_valid;

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp", 64'({rsp_carry, rsp_zero, rsp_err, rsp_data}), 64'(0));
    chk("rst_alu", 64'({alu_in_a, alu_in_b, alu_opcode}), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // Directed corner cases.
    run(4'h1, 32'h000000FF, 32'h00000001, 0, "add_ff_1");
    run(4'h1, 32'hFFFFFFFF, 32'h00000001, 1, "add_wrap");
    run(4'h2, 32'h00000000, 32'h00000001, 0, "sub_borrow");
    run(4'h2, 32'h12345678, 32'h12345678, 2, "sub_eq");
    run(4'h7, 32'hDEADBEEF, 32'h01020304, 0, "illegal7");

    // Back-pressure with a second command waiting.
    issue(4'h1, 32'h11111111, 32'h22222222);
    wait_rsp(4'h1, 32'h11111111, 32'h22222222, "bp_first");
    cmd_op = 4'h2; cmd_a = 32'h00000100; cmd_b = 32'h00000001; cmd_valid = 1'b1;
    drain(10, "bp_first");
    issue(4'h2, 32'h00000100, 32'h00000001);
    chk("bp_accept_wait", 64'(last_wait), 64'(0));
    wait_rsp(4'h2, 32'h00000100, 32'h00000001, "bp_second");
    drain(0, "bp_second");

    // Reset while the ADD sits in FIX for byte 1.
    issue(4'h1, 32'hFFFFFFFF, 32'h00000001);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("abort_in_fix_op", 64'(alu_opcode), 64'(3));
    reset_n = 1'b0;
    #1;
    chk("abort_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("abort_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("abort_rsp", 64'({rsp_carry, rsp_zero, rsp_err, rsp_data}), 64'(0));
    chk("abort_alu", 64'({alu_in_a, alu_in_b, alu_opcode}), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    seen_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen_valid = 1'b1;
    end
    chk("abort_no_rsp", 64'(seen_valid), 64'(0));
    run(4'h1, 32'h00000002, 32'h00000003, 0, "after_abort");

    // Randomised commands with random response back-pressure.
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 9) < 8) rop = ($urandom_range(0, 1) == 0) ? 4'h1 : 4'h2;
      else begin
        rop = 4'($urandom_range(3, 15));
        if (rop == 4'h3) rop = 4'h0;
      end
      ra = rand_word();
      rb = rand_word();
      run(rop, ra, rb, $urandom_range(0, 3), $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
